stream_source: RTL and testbench
================================

# stream_source

Stream producer for the token-stream integration fabric. After one control token is accepted on `inCtrl`, it emits a parameterised arithmetic sequence of 64-bit elements on `out0`, then an end-of-stream (EOS) token. It then issues one completion token on `outCtrl`. It is the transmit-side counterpart of the stream consumers in the integration benches, and acts as a synthesisable stimulus source for DUTs with a stream input.

## Interface
Parameters:
- `COUNT`, default 8 — number of data elements per run (0 allowed).
- `START`, default 0 — first element value, 64-bit.
- `STEP`, default 1 — increment between elements, 64-bit.

Ports:
- `clock`  input  1  — sole clock; all state updates on its rising edge.
- `reset`  input  1  — asynchronous, active-low reset.
- `inCtrl_valid`  input  1  — start token offered.
- `inCtrl_ready`  output  1  — start token can be accepted.
- `out0_valid`  output  1  — element or EOS token offered.
- `out0_ready`  input  1  — downstream accepts the token.
- `out0_data_field0`  output  64  — element value.
- `out0_data_field1`  output  1  — 1 = EOS token; 0 = data element.
- `outCtrl_valid`  output  1  — completion token offered.
- `outCtrl_ready`  input  1  — completion token accepted.

## Operation
- A handshake is a rising edge with valid=1 and ready=1.
- States: IDLE, EMIT, EOS, DONE.
- **IDLE**
  - `inCtrl_ready`=1.
  - On `inCtrl` handshake: load value=START and remaining=COUNT.
  - Next state is EMIT, or EOS if COUNT==0.
- **EMIT**
  - Drive `out0_valid`=1, field1=0, field0=value.
  - On handshake: value += STEP, truncated mod 2^64 (wraps silently). remaining -= 1.
  - On the handshake of the last element, go to EOS.
- **EOS**
  - Drive `out0_valid`=1, field1=1, field0=0.
  - On handshake, go to DONE.
- **DONE**
  - Drive `outCtrl_valid`=1.
  - On handshake, go to IDLE. The block is re-triggerable; each run restarts at START.
- `inCtrl_ready`=0 outside IDLE. Start tokens offered while busy are not consumed.
- Once a valid is asserted, it and its data stay stable until the handshake. Valid never depends combinationally on ready.
- All outputs are registered, or decoded from registered state only.
- Reset values: state=IDLE; `out0_valid`=0; `outCtrl_valid`=0; `inCtrl_ready`=1 once reset deasserts; field0=0; field1=0.
- Reset asserted mid-run: all valids drop immediately (asynchronously) and the run is abandoned. The first run after reset starts at START.

## Timing
- `inCtrl` handshake at edge N: first token (element, or EOS if COUNT==0) is valid after edge N.
- Full throughput: one token per cycle while `out0_ready`=1.
- Unstalled run: element k is presented in cycle N+1+k. EOS is presented in cycle N+1+COUNT.
- EOS handshake at edge M: `outCtrl_valid` is asserted after edge M. There is no bubble and no overlap.
- `outCtrl` handshake at edge P: `inCtrl_ready`=1 after edge P. The earliest next start token is accepted at edge P+1.
- Latency from start to EOS handshake: COUNT+1 cycles minimum, plus one cycle per stalled cycle.
- `inCtrl_valid` and `outCtrl_ready` are both high in DONE: only the `outCtrl` handshake occurs. The start token is taken no earlier than the following cycle.

## Configuration
- Macro `STREAM_SOURCE_STATS_EN`.
- Defined:
  - Adds output `stall_count`, 32 bits, reset 0.
  - Increments every cycle with `out0_valid`=1 and `out0_ready`=0.
  - Saturates at 2^32-1.
  - Cleared on each accepted `inCtrl` token.
- Undefined: no port and no logic. Behaviour is otherwise identical.

## Structure
- Shared package `stream_pkg` holds:
  - the state enum type (IDLE/EMIT/EOS/DONE);
  - the 64-bit element typedef;
  - the constants EOS_FLAG=1 and DATA_FLAG=0.
- Single module, no sub-module. Counter, value register and FSM are small enough to stay inline.

## Test plan
- COUNT=4, START=10, STEP=3, all readies held 1, one start pulse:
  - elements 10, 13, 16, 19 on consecutive cycles N+1..N+4;
  - EOS at N+5;
  - `outCtrl_valid` at N+6;
  - `inCtrl_ready` back to 1 at N+7.
- Same configuration, `out0_ready` toggled pseudo-randomly: same sequence. Field0 and field1 hold stable across every stalled cycle. With the macro defined, `stall_count` equals the number of low-ready cycles seen while valid.
- COUNT=0: EOS (field1=1) is the first and only `out0` token after start, followed by `outCtrl`.
- START=64'hFFFF_FFFF_FFFF_FFFE, STEP=1, COUNT=3: elements FFFF_FFFF_FFFF_FFFE, FFFF_FFFF_FFFF_FFFF, 0, then EOS.
- Reset pulled low during the element at index 2 of a COUNT=8 run:
  - `out0_valid` and `outCtrl_valid` go low before the next edge;
  - after release, `inCtrl_ready`=1;
  - a new start produces START again.
- `inCtrl_valid` held high throughout with `outCtrl_ready`=0 for 5 cycles in DONE: `inCtrl_ready` stays 0, no second run starts, and exactly one `outCtrl` handshake occurs. After the handshake, the second run begins one cycle later.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types for the stream source: FSM state encoding, element type and
// the EOS/data flag values carried on field1 of the output stream.
package stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_EOS  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef logic [63:0] elem_t;

  localparam logic EOS_FLAG  = 1'b1;
  localparam logic DATA_FLAG = 1'b0;

endpackage

// File: rtl/stream_source.sv
// Stream producer: one start token on inCtrl launches COUNT elements
// START, START+STEP, ... on out0, then an EOS token, then one completion
// token on outCtrl. All outputs decode directly from registered state so the
// async reset drops every valid immediately.
// Optional build macro: STREAM_SOURCE_STATS_EN adds a saturating stall_count.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for a start token, inCtrl_ready high
// EMIT    | presenting data element value_q, remaining_q left
// EOS     | presenting the end-of-stream token
// DONE    | presenting the completion token on outCtrl
module stream_source
  import stream_pkg::*;
#(
  parameter int unsigned COUNT = 8,
  parameter elem_t       START = 64'd0,
  parameter elem_t       STEP  = 64'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inCtrl_valid,
  output logic        inCtrl_ready,
  output logic        out0_valid,
  input  logic        out0_ready,
  output logic [63:0] out0_data_field0,
  output logic        out0_data_field1,
  output logic        outCtrl_valid,
  input  logic        outCtrl_ready
`ifdef STREAM_SOURCE_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  state_e      state_q, state_d;
  elem_t       value_q, value_d;
  logic [31:0] remaining_q, remaining_d;

  // Output decode from registered state only; nothing depends on a ready.
  assign inCtrl_ready     = (state_q == ST_IDLE);
  assign out0_valid       = (state_q == ST_EMIT) || (state_q == ST_EOS);
  assign out0_data_field0 = (state_q == ST_EMIT) ? value_q : '0;
  assign out0_data_field1 = (state_q == ST_EOS) ? EOS_FLAG : DATA_FLAG;
  assign outCtrl_valid    = (state_q == ST_DONE);

  // Next-state, element value and remaining-count update.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    remaining_d = remaining_q;
    unique case (state_q)
      ST_IDLE: begin
        if (inCtrl_valid) begin
          value_d     = START;
          remaining_d = COUNT;
          state_d     = (COUNT == 0) ? ST_EOS : ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out0_ready) begin
          value_d     = value_q + STEP;
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) begin
            state_d = ST_EOS;
          end
        end
      end
      ST_EOS: begin
        if (out0_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (outCtrl_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, value and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      value_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      remaining_q <= remaining_d;
    end
  end

`ifdef STREAM_SOURCE_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Stall counter: cleared on each start, counts valid-without-ready cycles, saturates.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && inCtrl_valid) begin
      stall_d = '0;
    end else if (out0_valid && !out0_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_stream_source.sv
// Bench for stream_source: four instances with different parameter sets,
// a table of runs checked through an expected-token queue, plus hand-written
// sequences for mid-run reset and a stalled completion handshake.
module tb_stream_source;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  in_v = '0, o_r = '0, c_r = '0;
  logic [3:0]  in_r, o_v, o_d1, c_v;
  logic [63:0] o_d0 [4];
`ifdef STREAM_SOURCE_STATS_EN
  logic [31:0] stall [4];
`endif

  stream_source #(.COUNT(4), .START(64'd10), .STEP(64'd3)) u_a (
    .clock(clk), .reset(rst_n), .inCtrl_valid(in_v[0]), .inCtrl_ready(in_r[0]),
    .out0_valid(o_v[0]), .out0_ready(o_r[0]), .out0_data_field0(o_d0[0]),
    .out0_data_field1(o_d1[0]), .outCtrl_valid(c_v[0]), .outCtrl_ready(c_r[0])
`ifdef STREAM_SOURCE_STATS_EN
    , .stall_count(stall[0])
`endif
  );

  stream_source #(.COUNT(0), .START(64'd10), .STEP(64'd3)) u_z (
    .clock(clk), .reset(rst_n), .inCtrl_valid(in_v[1]), .inCtrl_ready(in_r[1]),
    .out0_valid(o_v[1]), .out0_ready(o_r[1]), .out0_data_field0(o_d0[1]),
    .out0_data_field1(o_d1[1]), .outCtrl_valid(c_v[1]), .outCtrl_ready(c_r[1])
`ifdef STREAM_SOURCE_STATS_EN
    , .stall_count(stall[1])
`endif
  );

  stream_source #(.COUNT(3), .START(64'hFFFF_FFFF_FFFF_FFFE), .STEP(64'd1)) u_w (
    .clock(clk), .reset(rst_n), .inCtrl_valid(in_v[2]), .inCtrl_ready(in_r[2]),
    .out0_valid(o_v[2]), .out0_ready(o_r[2]), .out0_data_field0(o_d0[2]),
    .out0_data_field1(o_d1[2]), .outCtrl_valid(c_v[2]), .outCtrl_ready(c_r[2])
`ifdef STREAM_SOURCE_STATS_EN
    , .stall_count(stall[2])
`endif
  );

  stream_source #(.COUNT(8), .START(64'd10), .STEP(64'd3)) u_r (
    .clock(clk), .reset(rst_n), .inCtrl_valid(in_v[3]), .inCtrl_ready(in_r[3]),
    .out0_valid(o_v[3]), .out0_ready(o_r[3]), .out0_data_field0(o_d0[3]),
    .out0_data_field1(o_d1[3]), .outCtrl_valid(c_v[3]), .outCtrl_ready(c_r[3])
`ifdef STREAM_SOURCE_STATS_EN
    , .stall_count(stall[3])
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] d0;
    logic        d1;
    int          edge_no;
  } tok_t;

  typedef struct {
    int          inst;
    int          count;
    logic [63:0] start;
    logic [63:0] step;
    bit          stall;
    int          exp_ntok;
    logic [63:0] exp_last;
  } run_t;

  localparam logic [63:0] SENT = 64'hA5A5_5A5A_DEAD_BEEF;

  tok_t        sbq[$];
  int          act = -1;
  int          cnt;
  logic [63:0] st, sp;
  bit          chk_t, started, ctrl_done, pend;
  int          n_edge, ntok, stall_model;
  logic [63:0] last_elem, pend_d0;
  logic        pend_d1;

  // Monitor: samples on the falling edge; a valid&ready seen here handshakes at the next rising edge.
  always @(negedge clk) begin
    if (act >= 0) begin
      logic [63:0] v;
      tok_t e;
      if (pend) begin
        chk("hold_valid", 64'(o_v[act]), 64'd1);
        chk("hold_field0", o_d0[act], pend_d0);
        chk("hold_field1", 64'(o_d1[act]), 64'(pend_d1));
      end
      pend    = o_v[act] && !o_r[act];
      pend_d0 = o_d0[act];
      pend_d1 = o_d1[act];
      if (o_v[act] && !o_r[act]) stall_model++;
      if (started && !ctrl_done) chk("busy_in_ready", 64'(in_r[act]), 64'd0);
      if (in_v[act] && in_r[act] && !started) begin
        started = 1'b1;
        n_edge  = cyc + 1;
        v = st;
        for (int k = 0; k < cnt; k++) begin
          sbq.push_back('{v, 1'b0, n_edge + 1 + k});
          v = v + sp;
        end
        sbq.push_back('{64'd0, 1'b1, n_edge + 1 + cnt});
      end
      if (o_v[act] && o_r[act] && !ctrl_done) begin
        if (sbq.size() == 0) begin
          chk("extra_token", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("field0", o_d0[act], e.d0);
          chk("field1", 64'(o_d1[act]), 64'(e.d1));
          if (chk_t) chk("token_edge", 64'(cyc + 1), 64'(e.edge_no));
          ntok++;
          if (!o_d1[act]) last_elem = o_d0[act];
        end
      end
      if (c_v[act] && c_r[act] && !ctrl_done) begin
        chk("ctrl_after_all_tokens", 64'(sbq.size()), 64'd0);
        if (chk_t) chk("ctrl_edge", 64'(cyc + 1), 64'(n_edge + 2 + cnt));
        ctrl_done = 1'b1;
      end
    end
  end

  run_t runs[6];

  task automatic run_one(input int r);
    int i;
    run_t t;
    t = runs[r];
    i = t.inst;
    act = -1;
    sbq.delete();
    cnt = t.count; st = t.start; sp = t.step; chk_t = !t.stall;
    started = 1'b0; ctrl_done = 1'b0; pend = 1'b0;
    ntok = 0; stall_model = 0; last_elem = SENT;
    @(posedge clk); #1;
    in_v[i] = 1'b1; o_r[i] = 1'b1; c_r[i] = 1'b1;
    act = i;
    for (int c = 0; c < 300 && !ctrl_done; c++) begin
      @(posedge clk); #1;
      if (started) in_v[i] = 1'b0;
      o_r[i] = t.stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    in_v[i] = 1'b0;
    chk("run_completed", 64'(ctrl_done), 64'd1);
    @(negedge clk);
    chk("ready_after_ctrl", 64'(in_r[i]), 64'd1);
    act = -1;
    o_r[i] = 1'b1;
    chk("token_count", 64'(ntok), 64'(t.exp_ntok));
    chk("last_element", last_elem, t.exp_last);
`ifdef STREAM_SOURCE_STATS_EN
    chk("stall_count", 64'(stall[i]), 64'(stall_model));
`endif
  endtask

  initial begin
    bit found;
    runs[0] = '{0, 4, 64'd10, 64'd3, 1'b0, 5, 64'd19};
    runs[1] = '{0, 4, 64'd10, 64'd3, 1'b1, 5, 64'd19};
    runs[2] = '{1, 0, 64'd10, 64'd3, 1'b0, 1, SENT};
    runs[3] = '{2, 3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 4, 64'd0};
    runs[4] = '{3, 8, 64'd10, 64'd3, 1'b0, 9, 64'd31};
    runs[5] = '{2, 3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b1, 4, 64'd0};

    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_r), 64'hF);
    chk("rst_out0_valid", 64'(o_v), 64'h0);
    chk("rst_outctrl_valid", 64'(c_v), 64'h0);
    chk("rst_field1", 64'(o_d1), 64'h0);
    chk("rst_field0", o_d0[0] | o_d0[1] | o_d0[2] | o_d0[3], 64'd0);
`ifdef STREAM_SOURCE_STATS_EN
    chk("rst_stall_count", 64'(stall[0] | stall[1] | stall[2] | stall[3]), 64'd0);
`endif

    for (int r = 0; r < 6; r++) run_one(r);

    // Mid-run reset while element index 2 (value 16) of the COUNT=8 run is presented.
    act = -1;
    found = 1'b0;
    @(posedge clk); #1;
    in_v[3] = 1'b1; o_r[3] = 1'b1; c_r[3] = 1'b1;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (!in_r[3]) in_v[3] = 1'b0;
      if (o_v[3] && o_d0[3] == 64'd16) found = 1'b1;
    end
    chk("reach_elem2", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out0_valid", 64'(o_v[3]), 64'd0);
    chk("async_outctrl_valid", 64'(c_v[3]), 64'd0);
    in_v[3] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_r[3]), 64'd1);
    run_one(4);

    // Completion token stalled 5 cycles with a start token held high throughout.
    act = -1;
    found = 1'b0;
    @(posedge clk); #1;
    in_v[0] = 1'b1; o_r[0] = 1'b1; c_r[0] = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (c_v[0]) found = 1'b1;
    end
    chk("reach_done", 64'(found), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("done_in_ready", 64'(in_r[0]), 64'd0);
      chk("done_ctrl_valid", 64'(c_v[0]), 64'd1);
      chk("done_out0_valid", 64'(o_v[0]), 64'd0);
    end
    @(posedge clk); #1 c_r[0] = 1'b1;
    @(negedge clk);
    chk("ctrl_hs_valid", 64'(c_v[0]), 64'd1);
    @(posedge clk); #1 c_r[0] = 1'b0;
    @(negedge clk);
    chk("after_hs_ctrl_valid", 64'(c_v[0]), 64'd0);
    chk("after_hs_in_ready", 64'(in_r[0]), 64'd1);
    chk("after_hs_out0_valid", 64'(o_v[0]), 64'd0);
    @(posedge clk); #1 in_v[0] = 1'b0;
    @(negedge clk);
    chk("rerun_valid", 64'(o_v[0]), 64'd1);
    chk("rerun_first", o_d0[0], 64'd10);
    chk("rerun_in_ready", 64'(in_r[0]), 64'd0);
    c_r[0] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (in_r[0] && !c_v[0] && !o_v[0]) found = 1'b1;
    end
    chk("rerun_drained", 64'(found), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
